// File: rtl/barrel_unshifter.sv
// Sequential inverse barrel shifter: undoes a forward shift/rotate one bit per clock,
// with valid/ready on both sides and a recovered-bit mask for logical-shift mode.
module barrel_unshifter #(
  parameter int DATA_SIZE = 16,
  parameter bit ROTATION  = 1'b1,
  parameter bit DIRECTION = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_SIZE-1:0]         data_in,
  input  logic [$clog2(DATA_SIZE)-1:0] select,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_SIZE-1:0]         data_out,
  output logic [DATA_SIZE-1:0]         valid_mask,
  output logic                         busy
);

  localparam int SEL_W = $clog2(DATA_SIZE);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [DATA_SIZE-1:0] r_data;
  logic [DATA_SIZE-1:0] r_mask;
  logic [SEL_W-1:0]     r_cnt;
  logic                 w_load;
  logic                 w_shift;

  // One step against the forward direction; rotation keeps an all-ones mask all ones.
  function automatic logic [DATA_SIZE-1:0] step(input logic [DATA_SIZE-1:0] v);
    logic fill;
    if (DIRECTION) begin
      fill = ROTATION ? v[0] : 1'b0;
      return {fill, v[DATA_SIZE-1:1]};
    end else begin
      fill = ROTATION ? v[DATA_SIZE-1] : 1'b0;
      return {v[DATA_SIZE-2:0], fill};
    end
  endfunction

  always_comb begin
    w_next  = r_state;
    w_load  = 1'b0;
    w_shift = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_load = 1'b1;
          w_next = (select == '0) ? S_HOLD : S_SHIFT;
        end
      end
      S_SHIFT: begin
        w_shift = 1'b1;
        if (r_cnt == SEL_W'(1)) w_next = S_HOLD;
      end
      S_HOLD: begin
        if (out_ready) begin
          // A waiting word is reloaded on the same edge the result leaves.
          if (in_valid) begin
            w_load = 1'b1;
            w_next = (select == '0) ? S_HOLD : S_SHIFT;
          end else begin
            w_next = S_IDLE;
          end
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_data  <= '0;
      r_mask  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_load) begin
        r_data <= data_in;
        r_mask <= '1;
        r_cnt  <= select;
      end else if (w_shift) begin
        r_data <= step(r_data);
        r_mask <= step(r_mask);
        r_cnt  <= r_cnt - SEL_W'(1);
      end
    end
  end

  assign in_ready   = (r_state == S_IDLE) || ((r_state == S_HOLD) && out_ready);
  assign out_valid  = (r_state == S_HOLD);
  assign busy       = (r_state != S_IDLE);
  assign data_out   = r_data;
  assign valid_mask = r_mask;

endmodule
